// File: rtl/lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_share_ctrl
//
// Shares one 4-bit Fibonacci LFSR among NUM_REQ requesters. A round-robin
// arbiter picks one requester at a time. Each grant hands the current LFSR
// value to exactly one requester, and the LFSR then advances one step.
//
// Handshake: req_i is a level request held until granted. gnt_o is a
// one-cycle one-hot pulse that comes with rnd_o/rnd_valid_o. A requester
// drops req_i in the cycle after its grant. A request still high at that
// point counts as a new request.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   req_i        per-requester request (level)
//   seed_load_i  load seed_i into the LFSR (highest priority)
//   seed_i       seed value; zero is replaced by SEED
//   gnt_o        one-hot grant pulse, one cycle
//   rnd_o        random value, registered, holds when not valid
//   rnd_valid_o  high in the grant cycle
//   busy_o       high while the FSM is in GRANT (FSM state visibility)
//   grant_cnt_o  saturating grant count since reset / seed load
//   wrap_o       pulse in a grant cycle whose advance returns to the seed
// ---------------------------------------------------------------------------
module lfsr_share_ctrl #(
    parameter int         NUM_REQ = 4,
    parameter logic [3:0] SEED    = 4'hE,
    parameter int         CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               seed_load_i,
    input  logic [3:0]         seed_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [3:0]         rnd_o,
    output logic               rnd_valid_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   grant_cnt_o,
    output logic               wrap_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_lfsr;
    logic [3:0]           r_active;   // seed the wrap detector compares against
    logic [PTR_W-1:0]     r_ptr;      // index of the last winner
    logic [PTR_W-1:0]     r_win;      // winner latched in IDLE
    logic [NUM_REQ-1:0]   r_gnt;
    logic [3:0]           r_rnd;
    logic                 r_valid;
    logic [CNT_W-1:0]     r_cnt;

    logic [3:0]           w_nxt;
    logic [3:0]           w_seed;
    logic                 w_any;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]   w_win_oh;

    assign w_nxt  = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[1]};
    // A zero seed would lock the LFSR at zero forever.
    assign w_seed = (seed_i == 4'h0) ? SEED : seed_i;
    assign w_any  = |req_i;

    // Round-robin search starting one past the last winner, wrapping
    // modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lfsr   <= SEED;
            r_active <= SEED;
            r_ptr    <= PTR_W'(NUM_REQ - 1);
            r_win    <= '0;
            r_gnt    <= '0;
            r_rnd    <= 4'h0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // Grant outputs are single-cycle pulses.
            r_gnt   <= '0;
            r_valid <= 1'b0;
            if (seed_load_i) begin
                // A load overrides the advance of a grant in progress. The
                // grant itself was already presented this cycle, so the
                // pointer still moves to its winner.
                r_lfsr   <= w_seed;
                r_active <= w_seed;
                r_cnt    <= '0;
                r_state  <= S_IDLE;
                if (r_state == S_GRANT) begin
                    r_ptr <= r_win;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_win   <= w_win;
                            r_gnt   <= w_win_oh;
                            r_rnd   <= r_lfsr;
                            r_valid <= 1'b1;
                            r_state <= S_GRANT;
                        end
                    end
                    S_GRANT: begin
                        r_lfsr  <= w_nxt;
                        r_ptr   <= r_win;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign rnd_o       = r_rnd;
    assign rnd_valid_o = r_valid;
    assign busy_o      = (r_state == S_GRANT);
    assign grant_cnt_o = r_cnt;
    // A load in the grant cycle cancels the advance, so no wrap is reported.
    assign wrap_o      = (r_state == S_GRANT) && (w_nxt == r_active) && !seed_load_i;

endmodule
